rf_scoreboard_arb: RTL and testbench
====================================

RF_SCOREBOARD_ARB -- requirements
Module: rf_scoreboard_arb

Interface
REQ-001 SHALL have one clock and reset: asynchronous, active-low reset; ports named clk and rst (rst low = reset asserted).
REQ-002 SHALL have port clk  in  1  core clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports issue_valid  in  1, issue_rd/issue_rs1/issue_rs2  in  5  instruction in decode, with its dest/source register addresses.
REQ-005 SHALL have port issue_stall  out  1  decode must hold the instruction this cycle.
REQ-006 SHALL have ports wb_valid  in  1, wb_rd  in  5, wb_data  in  32  pipeline writeback; never back-pressured.
REQ-007 SHALL have ports lu_valid  in  1, lu_rd  in  5, lu_data  in  32, lu_ready  out  1  long-latency unit result, valid/ready handshake.
REQ-008 SHALL have ports rf_regwrite  out  1, rf_rd  out  5, rf_wdata  out  32  registered drive of the register-file write port.
REQ-009 SHALL have ports busy  out  32  pending-write bit per register; starve  out  1  long-unit result held too long.
REQ-010 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive held cycles before starve asserts.

Function
REQ-011 Scoreboard: busy[i] = 1 from issue of a write to xi until that write is selected for the port; busy[0] is constantly 0.
REQ-012 issue_stall SHALL be combinational: issue_valid & (busy[rs1] | busy[rs2] | busy[rd]), using registered busy only; same-cycle clears do not release the stall.
REQ-013 Issue accepted = issue_valid & !issue_stall; if issue_rd != 0, busy[issue_rd] sets at the next edge.
REQ-014 Same-edge set and clear of one register: set wins.
REQ-015 Holding buffer: one entry, states EMPTY/FULL; lu_ready = (state == EMPTY) | !wb_valid.
REQ-016 lu handshake (lu_valid & lu_ready) SHALL capture lu_rd/lu_data into the buffer; capture while draining is permitted; the buffer stays FULL.
REQ-017 Write-port select each cycle: wb_valid -> wb source; else buffer FULL -> buffer source, which drains; else no write.
REQ-018 Selected source SHALL appear on rf_regwrite/rf_rd/rf_wdata at the next edge (latency 1). busy[rd] clears at that same edge.
REQ-019 Writes with rd = 0 SHALL be suppressed: rf_regwrite stays 0, no busy change, and a buffer holding rd 0 still drains.
REQ-020 When no write is selected, rf_regwrite = 0 and rf_rd/rf_wdata hold their last values.
REQ-021 Starve counter: 3-bit saturating, counts cycles the buffer is FULL and not drained, clears on drain. starve = (count >= STARVE_LIMIT-1), registered.
REQ-022 An lu result SHALL never be dropped or overwritten while FULL and undrained.

Reset
REQ-023 Reset SHALL apply asynchronously: busy = 0, buffer EMPTY, counter 0, starve 0, rf_regwrite 0, rf_rd 0, rf_wdata 0.
REQ-024 Reset mid-operation SHALL discard buffered and in-flight writes. issue_stall and lu_ready SHALL reflect the reset state (0 and 1) while rst is low.
REQ-025 After rst deasserts, the first edge SHALL behave as normal operation.

Structure
REQ-026 Shared package SHALL hold XLEN=32, NREG=32, RADDR_W=5, the buffer state enum {EMPTY, FULL} and the STARVE_LIMIT default.
REQ-027 Sub-module rf_wb_buffer SHALL implement the one-entry buffer and starve counter. Scoreboard, stall and select logic SHALL stay in the top module.

Verification
REQ-028 Sequence: issue rd=5; next cycle issue rs1=5 -> stall=1. wb_valid rd=5 data=0xDEADBEEF -> next edge rf_regwrite=1, rf_rd=5, rf_wdata=0xDEADBEEF, busy[5]=0. Stall drops the following cycle.
REQ-029 Same cycle wb_valid rd=3 data=0x11 and lu_valid rd=7 data=0x22 -> lu_ready=1, buffer captures. Edge 1 writes x3=0x11; edge 2 writes x7=0x22.
REQ-030 Buffer FULL and wb_valid held 10 cycles -> lu_ready=0 throughout and starve=1 by cycle 8. wb_valid drops -> x7 written, starve=0, count=0.
REQ-031 Issue rd=0, then wb rd=0 data=0xFF -> busy stays 0, rf_regwrite stays 0, no stall on rs1=0.
REQ-032 Buffer FULL and busy[9]=1, then rst low mid-cycle -> outputs go to reset values immediately, lu_ready=1, no write after release.

Source files
------------

// File: rtl/rf_scoreboard_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_scoreboard_arb_pkg
// Shared widths, defaults and the holding-buffer state type for the
// register-file scoreboard / write-port arbiter and its buffer sub-module.
// ---------------------------------------------------------------------------
package rf_scoreboard_arb_pkg;

    localparam int XLEN                 = 32;  // register data width
    localparam int NREG                 = 32;  // architectural registers
    localparam int RADDR_W              = 5;   // register address width
    localparam int STARVE_LIMIT_DEFAULT = 8;   // held cycles before starve
    localparam int STARVE_CNT_W         = 3;   // saturating starve counter

    // One-entry holding buffer for long-latency unit results.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/rf_wb_buffer.sv
// ---------------------------------------------------------------------------
// rf_wb_buffer
// One-entry holding buffer for long-latency unit results plus the starve
// counter. The pipeline writeback always owns the register-file port; the
// buffer drains only in cycles with no writeback, and refuses new results
// only while it is FULL and cannot drain, so nothing is ever overwritten.
//
// Ports
//   clk, rst          core clock, asynchronous active-low reset
//   wb_valid          pipeline writeback present this cycle (blocks drain)
//   lu_valid/lu_rd/lu_data, lu_ready   long-unit result handshake
//   buf_full          buffer holds a result
//   buf_rd/buf_data   buffered result (meaningful only while buf_full)
//   starve            registered: buffered result has waited too long
// ---------------------------------------------------------------------------
module rf_wb_buffer
    import rf_scoreboard_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_valid,
    input  logic               lu_valid,
    input  logic [RADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]    lu_data,
    output logic               lu_ready,
    output logic               buf_full,
    output logic [RADDR_W-1:0] buf_rd,
    output logic [XLEN-1:0]    buf_data,
    output logic               starve
);

    localparam logic [31:0] STARVE_THRESH = 32'(STARVE_LIMIT - 1);

    buf_state_t              state_q, state_d;
    logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
    logic                    capture;
    logic                    drain;

    assign buf_full = (state_q == FULL);
    // A FULL buffer can still accept when it drains in the same cycle.
    assign lu_ready = !buf_full || !wb_valid;
    assign capture  = lu_valid && lu_ready;
    assign drain    = buf_full && !wb_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (capture) begin
            state_d = FULL;
        end else if (drain) begin
            state_d = EMPTY;
        end
        if (drain) begin
            cnt_d = '0;
        end else if (buf_full && (cnt_q != '1)) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            starve  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Built from the next count so starve always agrees with the counter.
            starve  <= (32'(cnt_d) >= STARVE_THRESH);
        end
    end

    // NOTE: payload storage has no reset; its validity is carried entirely by
    // state_q, so resetting it would only cost reset routing.
    always_ff @(posedge clk) begin
        if (capture) begin
            buf_rd   <= lu_rd;
            buf_data <= lu_data;
        end
    end

endmodule

// File: rtl/rf_scoreboard_arb.sv
// ---------------------------------------------------------------------------
// rf_scoreboard_arb
// Register scoreboard and register-file write-port arbiter. Tracks one
// pending-write bit per register, stalls decode on any hazard against a
// pending write, and arbitrates the single write port between the pipeline
// writeback (priority) and a buffered long-latency unit result.
//
// Ports
//   clk, rst                                core clock, async active-low reset
//   issue_valid, issue_rd/rs1/rs2, issue_stall   decode issue and hazard stall
//   wb_valid, wb_rd, wb_data                pipeline writeback (never stalled)
//   lu_valid, lu_rd, lu_data, lu_ready      long-unit result handshake
//   rf_regwrite, rf_rd, rf_wdata            registered register-file write
//   busy                                    pending-write bit per register
//   starve                                  buffered result held too long
// ---------------------------------------------------------------------------
module rf_scoreboard_arb
    import rf_scoreboard_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [RADDR_W-1:0] issue_rd,
    input  logic [RADDR_W-1:0] issue_rs1,
    input  logic [RADDR_W-1:0] issue_rs2,
    output logic               issue_stall,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    input  logic               lu_valid,
    input  logic [RADDR_W-1:0] lu_rd,
    input  logic [XLEN-1:0]    lu_data,
    output logic               lu_ready,
    output logic               rf_regwrite,
    output logic [RADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]    rf_wdata,
    output logic [NREG-1:0]    busy,
    output logic               starve
);

    logic               buf_full;
    logic [RADDR_W-1:0] buf_rd;
    logic [XLEN-1:0]    buf_data;
    logic               sel_valid;
    logic [RADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]    sel_data;
    logic               sel_write;
    logic               issue_accept;
    logic [NREG-1:0]    set_mask;
    logic [NREG-1:0]    clr_mask;
    logic [NREG-1:0]    busy_d;

    rf_wb_buffer #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_buffer (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .lu_valid (lu_valid),
        .lu_rd    (lu_rd),
        .lu_data  (lu_data),
        .lu_ready (lu_ready),
        .buf_full (buf_full),
        .buf_rd   (buf_rd),
        .buf_data (buf_data),
        .starve   (starve)
    );

    // Registered busy only: a write completing this cycle does not release
    // the stall until the following cycle.
    assign issue_stall  = issue_valid && (busy[issue_rs1] || busy[issue_rs2] || busy[issue_rd]);
    assign issue_accept = issue_valid && !issue_stall;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (wb_valid) begin
            sel_valid = 1'b1;
            sel_rd    = wb_rd;
            sel_data  = wb_data;
        end else if (buf_full) begin
            sel_valid = 1'b1;
            sel_rd    = buf_rd;
            sel_data  = buf_data;
        end
    end

    // x0 writes still consume their slot (a buffered x0 drains) but never
    // reach the register file or the scoreboard.
    assign sel_write = sel_valid && (sel_rd != '0);

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (sel_write) begin
            clr_mask[sel_rd] = 1'b1;
        end
        if (issue_accept && (issue_rd != '0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        // Set is applied after clear so a new issue wins over a completing write.
        busy_d    = (busy & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy        <= '0;
            rf_regwrite <= 1'b0;
            rf_rd       <= '0;
            rf_wdata    <= '0;
        end else begin
            busy        <= busy_d;
            rf_regwrite <= sel_write;
            if (sel_write) begin
                rf_rd    <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_scoreboard_arb.sv
// ---------------------------------------------------------------------------
// tb_rf_scoreboard_arb
// Scenario tasks plus a randomized run, checked against a transaction-level
// reference model: a bit array of pending writes, a queue standing in for the
// holding buffer, and a plain count of cycles a result has waited.
// ---------------------------------------------------------------------------
module tb_rf_scoreboard_arb;

    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_regwrite;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] busy;
    logic        starve;

    rf_scoreboard_arb #(.STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_stall (issue_stall),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .lu_valid    (lu_valid),
        .lu_rd       (lu_rd),
        .lu_data     (lu_data),
        .lu_ready    (lu_ready),
        .rf_regwrite (rf_regwrite),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .busy        (busy),
        .starve      (starve)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    bit          m_busy[32];
    wr_t         m_buf[$];
    int          m_held;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    bit          m_known;   // rf_rd/rf_wdata are predictable

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic bit m_stall();
        return issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rd]);
    endfunction

    function automatic bit m_ready();
        return (m_buf.size() == 0) || !wb_valid;
    endfunction

    function automatic bit m_starve();
        int sat = (m_held > 7) ? 7 : m_held;
        return sat >= LIMIT - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_buf.delete();
        m_held  = 0;
        m_we    = 1'b0;
        m_rd    = '0;
        m_wd    = '0;
        m_known = 1'b1;
    endtask

    task automatic model_edge();
        bit  stall     = m_stall();
        bit  ready     = m_ready();
        bit  was_full  = (m_buf.size() != 0);
        bit  have      = 1'b0;
        bit  drained   = 1'b0;
        wr_t src;
        if (wb_valid) begin
            src.rd   = wb_rd;
            src.data = wb_data;
            have     = 1'b1;
        end else if (was_full) begin
            src     = m_buf.pop_front();
            have    = 1'b1;
            drained = 1'b1;
        end
        m_we = 1'b0;
        if (have) begin
            if (src.rd != 0) begin
                m_we             = 1'b1;
                m_rd             = src.rd;
                m_wd             = src.data;
                m_known          = 1'b1;
                m_busy[src.rd]   = 1'b0;
            end else begin
                m_known = 1'b0;
            end
        end
        if (issue_valid && !stall && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        if (lu_valid && ready) m_buf.push_back('{rd: lu_rd, data: lu_data});
        if (drained) m_held = 0;
        else if (was_full) m_held++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        wb_valid    = 1'b0; wb_rd    = '0; wb_data   = '0;
        lu_valid    = 1'b0; lu_rd    = '0; lu_data   = '0;
    endtask

    // Advance one clock; the model follows the DUT (or resets with it).
    task automatic cycle();
        @(posedge clk);
        if (rst) model_edge();
        else     model_reset();
        #2;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        issue_valid = 1'b1; issue_rs1 = 5'd3; issue_rd = 5'd4;
        wb_valid    = 1'b1; wb_rd = 5'd6; wb_data = 32'h1234;
        model_reset();
        #12;
        n_total++; if (busy !== 32'h0) $display("FAIL reset_busy got=%h exp=0", busy); else n_pass++;
        n_total++; if (rf_regwrite !== 1'b0) $display("FAIL reset_regwrite got=%b exp=0", rf_regwrite); else n_pass++;
        n_total++; if (rf_rd !== 5'd0 || rf_wdata !== 32'h0) $display("FAIL reset_rfdata got=%0d/%h exp=0/0", rf_rd, rf_wdata); else n_pass++;
        n_total++; if (starve !== 1'b0) $display("FAIL reset_starve got=%b exp=0", starve); else n_pass++;
        n_total++; if (lu_ready !== 1'b1) $display("FAIL reset_lu_ready got=%b exp=1", lu_ready); else n_pass++;
        n_total++; if (issue_stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", issue_stall); else n_pass++;
        @(posedge clk); #2;
        rst = 1'b1;
        idle();
        #1;
        cycle();
        n_total++; if (rf_regwrite !== 1'b0 || busy !== 32'h0) $display("FAIL post_reset got=%b/%h exp=0/0", rf_regwrite, busy); else n_pass++;
    endtask

    task automatic test_raw_hazard();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        n_total++; if (issue_stall !== 1'b0) $display("FAIL raw_first_issue got=%b exp=0", issue_stall); else n_pass++;
        cycle();
        n_total++; if (busy[5] !== 1'b1) $display("FAIL raw_busy_set got=%b exp=1", busy[5]); else n_pass++;
        issue_rd = 5'd0; issue_rs1 = 5'd5;
        #1;
        n_total++; if (issue_stall !== 1'b1) $display("FAIL raw_stall got=%b exp=1", issue_stall); else n_pass++;
        cycle();
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        #1;
        n_total++; if (issue_stall !== 1'b1) $display("FAIL raw_stall_same_cycle got=%b exp=1", issue_stall); else n_pass++;
        cycle();
        n_total++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF)
            $display("FAIL raw_write got=%b/%0d/%h exp=1/5/deadbeef", rf_regwrite, rf_rd, rf_wdata); else n_pass++;
        n_total++; if (busy[5] !== 1'b0) $display("FAIL raw_busy_clear got=%b exp=0", busy[5]); else n_pass++;
        wb_valid = 1'b0;
        #1;
        n_total++; if (issue_stall !== 1'b0) $display("FAIL raw_stall_release got=%b exp=0", issue_stall); else n_pass++;
        cycle();
        idle();
    endtask

    task automatic test_collision();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h22;
        #1;
        n_total++; if (lu_ready !== 1'b1) $display("FAIL coll_lu_ready got=%b exp=1", lu_ready); else n_pass++;
        cycle();
        n_total++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h11)
            $display("FAIL coll_edge1 got=%b/%0d/%h exp=1/3/11", rf_regwrite, rf_rd, rf_wdata); else n_pass++;
        idle();
        #1;
        cycle();
        n_total++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h22)
            $display("FAIL coll_edge2 got=%b/%0d/%h exp=1/7/22", rf_regwrite, rf_rd, rf_wdata); else n_pass++;
        cycle();
        n_total++; if (rf_regwrite !== 1'b0) $display("FAIL coll_idle got=%b exp=0", rf_regwrite); else n_pass++;
    endtask

    task automatic test_starve();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h22;
        #1;
        cycle();
        for (int i = 1; i <= 10; i++) begin
            wb_valid = 1'b1; wb_rd = 5'(10 + i); wb_data = 32'(i * 100);
            lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'hBAD;
            #1;
            n_total++; if (lu_ready !== 1'b0) $display("FAIL starve_lu_ready c%0d got=%b exp=0", i, lu_ready); else n_pass++;
            cycle();
            n_total++; if (starve !== m_starve() || starve !== (i >= LIMIT - 1))
                $display("FAIL starve_flag c%0d got=%b exp=%b", i, starve, m_starve()); else n_pass++;
            n_total++; if (rf_rd !== wb_rd || rf_wdata !== wb_data)
                $display("FAIL starve_wb c%0d got=%0d/%h exp=%0d/%h", i, rf_rd, rf_wdata, wb_rd, wb_data); else n_pass++;
        end
        idle();
        #1;
        n_total++; if (lu_ready !== 1'b1) $display("FAIL starve_drain_ready got=%b exp=1", lu_ready); else n_pass++;
        cycle();
        n_total++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h22)
            $display("FAIL starve_drain got=%b/%0d/%h exp=1/7/22", rf_regwrite, rf_rd, rf_wdata); else n_pass++;
        n_total++; if (starve !== 1'b0) $display("FAIL starve_clear got=%b exp=0", starve); else n_pass++;
        cycle();
        n_total++; if (rf_regwrite !== 1'b0 || rf_rd !== 5'd7 || rf_wdata !== 32'h22)
            $display("FAIL starve_hold got=%b/%0d/%h exp=0/7/22", rf_regwrite, rf_rd, rf_wdata); else n_pass++;
    endtask

    task automatic test_x0();
        idle();
        issue_valid = 1'b1;
        #1;
        n_total++; if (issue_stall !== 1'b0) $display("FAIL x0_stall got=%b exp=0", issue_stall); else n_pass++;
        cycle();
        n_total++; if (busy !== 32'h0) $display("FAIL x0_issue_busy got=%h exp=0", busy); else n_pass++;
        idle();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
        #1;
        cycle();
        n_total++; if (rf_regwrite !== 1'b0 || busy !== 32'h0) $display("FAIL x0_wb got=%b/%h exp=0/0", rf_regwrite, busy); else n_pass++;
        wb_rd = 5'd1; wb_data = 32'h31;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h33;
        #1;
        cycle();
        idle();
        #1;
        cycle();
        n_total++; if (rf_regwrite !== 1'b0) $display("FAIL x0_buf_drain got=%b exp=0", rf_regwrite); else n_pass++;
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h44;
        #1;
        n_total++; if (lu_ready !== 1'b1) $display("FAIL x0_buf_empty got=%b exp=1", lu_ready); else n_pass++;
        cycle();
        n_total++; if (rf_regwrite !== 1'b1 || rf_rd !== 5'd2 || rf_wdata !== 32'h44)
            $display("FAIL x0_after got=%b/%0d/%h exp=1/2/44", rf_regwrite, rf_rd, rf_wdata); else n_pass++;
        idle();
    endtask

    task automatic test_mid_reset();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        cycle();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'h66;
        #1;
        cycle();
        lu_valid = 1'b0;
        wb_rd = 5'd2; wb_data = 32'h77;
        issue_valid = 1'b1; issue_rs1 = 5'd9;
        #1;
        n_total++; if (lu_ready !== 1'b0 || issue_stall !== 1'b1 || busy[9] !== 1'b1)
            $display("FAIL mid_pre got=%b/%b/%b exp=0/1/1", lu_ready, issue_stall, busy[9]); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_total++; if (busy !== 32'h0 || rf_regwrite !== 1'b0 || starve !== 1'b0)
            $display("FAIL mid_rst_state got=%h/%b/%b exp=0/0/0", busy, rf_regwrite, starve); else n_pass++;
        n_total++; if (rf_rd !== 5'd0 || rf_wdata !== 32'h0) $display("FAIL mid_rst_rf got=%0d/%h exp=0/0", rf_rd, rf_wdata); else n_pass++;
        n_total++; if (lu_ready !== 1'b1 || issue_stall !== 1'b0)
            $display("FAIL mid_rst_comb got=%b/%b exp=1/0", lu_ready, issue_stall); else n_pass++;
        cycle();
        cycle();
        rst = 1'b1;
        idle();
        #1;
        cycle();
        n_total++; if (rf_regwrite !== 1'b0 || busy !== 32'h0) $display("FAIL mid_release1 got=%b/%h exp=0/0", rf_regwrite, busy); else n_pass++;
        cycle();
        n_total++; if (rf_regwrite !== 1'b0 || rf_rd !== 5'd0) $display("FAIL mid_release2 got=%b/%0d exp=0/0", rf_regwrite, rf_rd); else n_pass++;
    endtask

    task automatic test_random();
        int wb_pct;
        for (int c = 0; c < 400; c++) begin
            wb_pct      = (c < 200) ? 60 : 85;
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            wb_valid    = ($urandom_range(0, 99) < wb_pct);
            wb_rd       = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            lu_valid    = ($urandom_range(0, 99) < 40);
            lu_rd       = 5'($urandom_range(0, 7));
            lu_data     = $urandom;
            #1;
            n_total++; if (issue_stall !== m_stall()) $display("FAIL rnd_stall c%0d got=%b exp=%b", c, issue_stall, m_stall()); else n_pass++;
            n_total++; if (lu_ready !== m_ready()) $display("FAIL rnd_lu_ready c%0d got=%b exp=%b", c, lu_ready, m_ready()); else n_pass++;
            cycle();
            n_total++; if (rf_regwrite !== m_we) $display("FAIL rnd_regwrite c%0d got=%b exp=%b", c, rf_regwrite, m_we); else n_pass++;
            if (m_known) begin
                n_total++; if (rf_rd !== m_rd || rf_wdata !== m_wd)
                    $display("FAIL rnd_rfdata c%0d got=%0d/%h exp=%0d/%h", c, rf_rd, rf_wdata, m_rd, m_wd); else n_pass++;
            end
            n_total++; if (busy !== m_busy_vec()) $display("FAIL rnd_busy c%0d got=%h exp=%h", c, busy, m_busy_vec()); else n_pass++;
            n_total++; if (starve !== m_starve()) $display("FAIL rnd_starve c%0d got=%b exp=%b", c, starve, m_starve()); else n_pass++;
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_raw_hazard();
        test_collision();
        test_starve();
        test_x0();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
